// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared constants for the MEM stage.
//   - funct3 access size/sign codes for loads and stores
//   - FSM state encoding for the memory handshake
//   - writeback-select encodings carried through MEM/WB
//   - is_misaligned(): alignment rule shared by the stage
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no transaction outstanding
    ST_REQ  = 2'd1,  // request held until dmem_ready
    ST_RESP = 2'd2   // load accepted, waiting for dmem_rvalid
  } state_e;

  // funct3[1:0] encodes the size: 00 byte, 01 half, 10 word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if (f3[1:0] == 2'b01) mis = a[0];
    else if (f3[1:0] == 2'b10) mis = (a != 2'b00);
    return mis;
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// mem_align: combinational lane logic for data memory accesses.
// Ports:
//   funct3     in   access size/sign
//   addr_lo    in   byte offset within the word (a[1:0])
//   st_data    in   raw store data (low bits significant)
//   rd_data    in   word returned by memory
//   be         out  store byte enables
//   wdata      out  store data replicated across all lanes
//   load_data  out  lane-selected, sign/zero-extended load result
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]          funct3,
  input  logic [1:0]          addr_lo,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W/8-1:0] be,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   load_data
);

  localparam int NB = DATA_W / 8;

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Halfwords are only ever issued aligned, so a[1] alone picks the half.
  assign lane_byte = rd_data[{addr_lo, 3'b000} +: 8];
  assign lane_half = rd_data[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    be    = '1;
    wdata = st_data;
    unique case (funct3[1:0])
      2'b00: begin
        be    = {{(NB-1){1'b0}}, 1'b1} << addr_lo;
        wdata = {NB{st_data[7:0]}};
      end
      2'b01: begin
        be    = {{(NB-2){1'b0}}, 2'b11} << addr_lo;
        wdata = {(NB/2){st_data[15:0]}};
      end
      default: begin
        be    = '1;
        wdata = st_data;
      end
    endcase
  end

  always_comb begin
    load_data = rd_data;
    case (funct3)
      F3_B:    load_data = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
      F3_H:    load_data = {{(DATA_W-16){lane_half[15]}}, lane_half};
      F3_BU:   load_data = {{(DATA_W-8){1'b0}}, lane_byte};
      F3_HU:   load_data = {{(DATA_W-16){1'b0}}, lane_half};
      default: load_data = rd_data;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: RV32I memory stage. Issues data-memory requests for loads and
// stores, stalls the upstream pipeline while a transaction is outstanding,
// and updates the MEM/WB register.
// Ports:
//   clk, rst                      clock, async active-high reset
//   ex_*                          EX/MEM register contents
//   flush                         turn this cycle's MEM/WB update into a bubble
//   mem_stall                     freeze upstream stages
//   dmem_*                        data memory request / response
//   wb_*                          MEM/WB register
//   dbg_state                     current FSM state (mem_stage_pkg::state_e)
//
// Handshake: dmem_req/we/be/addr/wdata are held stable from issue until the
// cycle dmem_ready=1 (acceptance). A load completes on the cycle dmem_rvalid=1,
// which may be the acceptance cycle itself. A store completes on acceptance.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RD_W     = 5,
  parameter int WB_SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  input  logic [DATA_W-1:0]   ex_alu_out,
  input  logic [DATA_W-1:0]   ex_writedata,
  input  logic [RD_W-1:0]     ex_rd,
  input  logic                ex_memread_en,
  input  logic                ex_memwrite_en,
  input  logic                ex_regwrite_en,
  input  logic [WB_SEL_W-1:0] ex_wb_sel,
  input  logic [2:0]          ex_funct3,
  input  logic                flush,
  output logic                mem_stall,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_ready,
  input  logic                dmem_rvalid,
  input  logic [DATA_W-1:0]   dmem_rdata,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic                wb_regwrite_en,
  output logic [WB_SEL_W-1:0] wb_wb_sel,
  output logic [DATA_W-1:0]   wb_alu_out,
  output logic [DATA_W-1:0]   wb_load_data,
  output logic                wb_misaligned,
  output logic [1:0]          dbg_state
);

  state_e state_q, state_d;
  logic   kill_q, kill_d;  // a flush arrived while the transaction was outstanding

  // Copy of the instruction taken at issue; drives the bus and MEM/WB later.
  logic                req_we_q,       req_we_d;
  logic [2:0]          req_f3_q,       req_f3_d;
  logic [DATA_W-1:0]   req_alu_q,      req_alu_d;
  logic [DATA_W-1:0]   req_wdata_q,    req_wdata_d;
  logic [RD_W-1:0]     req_rd_q,       req_rd_d;
  logic                req_regwrite_q, req_regwrite_d;
  logic [WB_SEL_W-1:0] req_wb_sel_q,   req_wb_sel_d;

  logic                wb_valid_q,     wb_valid_d;
  logic [RD_W-1:0]     wb_rd_q,        wb_rd_d;
  logic                wb_regwrite_q,  wb_regwrite_d;
  logic [WB_SEL_W-1:0] wb_wb_sel_q,    wb_wb_sel_d;
  logic [DATA_W-1:0]   wb_alu_out_q,   wb_alu_out_d;
  logic [DATA_W-1:0]   wb_load_q,      wb_load_d;
  logic                wb_mis_q,       wb_mis_d;

  logic is_memop, mis_acc, idle, issue, req_c, complete, latch_en, discard;

  logic                cur_we, cur_regwrite;
  logic [2:0]          cur_f3;
  logic [DATA_W-1:0]   cur_alu, cur_wdata;
  logic [RD_W-1:0]     cur_rd;
  logic [WB_SEL_W-1:0] cur_wb_sel;

  logic [DATA_W/8-1:0] al_be;
  logic [DATA_W-1:0]   al_wdata, al_load;

  assign idle     = (state_q == ST_IDLE);
  assign is_memop = ex_valid && (ex_memread_en || ex_memwrite_en);
  assign mis_acc  = is_memop && is_misaligned(ex_funct3, ex_alu_out[1:0]);
  assign issue    = idle && is_memop && !mis_acc;

  // In IDLE the live EX fields describe the access; afterwards the copy does.
  assign cur_we       = idle ? ex_memwrite_en : req_we_q;
  assign cur_f3       = idle ? ex_funct3      : req_f3_q;
  assign cur_alu      = idle ? ex_alu_out     : req_alu_q;
  assign cur_wdata    = idle ? ex_writedata   : req_wdata_q;
  assign cur_rd       = idle ? ex_rd          : req_rd_q;
  assign cur_regwrite = idle ? ex_regwrite_en : req_regwrite_q;
  assign cur_wb_sel   = idle ? ex_wb_sel      : req_wb_sel_q;

  mem_align #(.DATA_W(DATA_W)) u_align (
    .funct3    (cur_f3),
    .addr_lo   (cur_alu[1:0]),
    .st_data   (cur_wdata),
    .rd_data   (dmem_rdata),
    .be        (al_be),
    .wdata     (al_wdata),
    .load_data (al_load)
  );

  // FSM next state
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    req_c    = 1'b0;
    complete = 1'b0;
    latch_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          req_c    = 1'b1;
          latch_en = 1'b1;
          kill_d   = flush;
          if (dmem_ready) begin
            if (ex_memwrite_en || dmem_rvalid) complete = 1'b1;
            else state_d = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (flush) kill_d = 1'b1;
        if (dmem_ready) begin
          if (req_we_q || dmem_rvalid) complete = 1'b1;
          else state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush) kill_d = 1'b1;
        if (dmem_rvalid) complete = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (complete) begin
      state_d = ST_IDLE;
      kill_d  = 1'b0;
    end
  end

  // Issue-time copy of the instruction
  always_comb begin
    req_we_d       = req_we_q;
    req_f3_d       = req_f3_q;
    req_alu_d      = req_alu_q;
    req_wdata_d    = req_wdata_q;
    req_rd_d       = req_rd_q;
    req_regwrite_d = req_regwrite_q;
    req_wb_sel_d   = req_wb_sel_q;
    if (latch_en) begin
      req_we_d       = ex_memwrite_en;
      req_f3_d       = ex_funct3;
      req_alu_d      = ex_alu_out;
      req_wdata_d    = ex_writedata;
      req_rd_d       = ex_rd;
      req_regwrite_d = ex_regwrite_en;
      req_wb_sel_d   = ex_wb_sel;
    end
  end

  // kill_q is always clear in IDLE, so this covers both same-cycle and
  // earlier flushes.
  assign discard = flush || kill_q;

  // MEM/WB next value: a bubble unless something retires this cycle
  always_comb begin
    wb_valid_d    = 1'b0;
    wb_rd_d       = '0;
    wb_regwrite_d = 1'b0;
    wb_wb_sel_d   = '0;
    wb_alu_out_d  = '0;
    wb_load_d     = '0;
    wb_mis_d      = 1'b0;
    if (!discard) begin
      if (idle && ex_valid && !issue) begin
        // non-memory instruction, or a misaligned access faulting in place
        wb_valid_d    = 1'b1;
        wb_rd_d       = ex_rd;
        wb_regwrite_d = ex_regwrite_en && !mis_acc;
        wb_wb_sel_d   = ex_wb_sel;
        wb_alu_out_d  = ex_alu_out;
        wb_mis_d      = mis_acc;
      end else if (complete) begin
        wb_valid_d    = 1'b1;
        wb_rd_d       = cur_rd;
        wb_regwrite_d = cur_regwrite;
        wb_wb_sel_d   = cur_wb_sel;
        wb_alu_out_d  = cur_alu;
        wb_load_d     = cur_we ? '0 : al_load;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      kill_q         <= 1'b0;
      req_we_q       <= 1'b0;
      req_f3_q       <= '0;
      req_alu_q      <= '0;
      req_wdata_q    <= '0;
      req_rd_q       <= '0;
      req_regwrite_q <= 1'b0;
      req_wb_sel_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
      wb_wb_sel_q    <= '0;
      wb_alu_out_q   <= '0;
      wb_load_q      <= '0;
      wb_mis_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      kill_q         <= kill_d;
      req_we_q       <= req_we_d;
      req_f3_q       <= req_f3_d;
      req_alu_q      <= req_alu_d;
      req_wdata_q    <= req_wdata_d;
      req_rd_q       <= req_rd_d;
      req_regwrite_q <= req_regwrite_d;
      req_wb_sel_q   <= req_wb_sel_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      wb_wb_sel_q    <= wb_wb_sel_d;
      wb_alu_out_q   <= wb_alu_out_d;
      wb_load_q      <= wb_load_d;
      wb_mis_q       <= wb_mis_d;
    end
  end

  // Reset also masks the combinational request path so the bus drops at once.
  assign dmem_req   = req_c && !rst;
  assign dmem_we    = req_c && !rst && cur_we;
  assign dmem_be    = (req_c && !rst) ? al_be : '0;
  assign dmem_addr  = {cur_alu[DATA_W-1:2], 2'b00};
  assign dmem_wdata = al_wdata;
  assign mem_stall  = !rst && (state_d != ST_IDLE);

  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_regwrite_en = wb_regwrite_q;
  assign wb_wb_sel      = wb_wb_sel_q;
  assign wb_alu_out     = wb_alu_out_q;
  assign wb_load_data   = wb_load_q;
  assign wb_misaligned  = wb_mis_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, datapath width (32 only for RV32I; 64 reserved); RD_W, default 5, destination register index width; WB_SEL_W, default 2, writeback select width.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset, on ports clk and rst.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- ex_valid  in  1  EX/MEM holds a live instruction
- ex_alu_out  in  DATA_W  effective address or ALU result
- ex_writedata  in  DATA_W  store data
- ex_rd  in  RD_W  destination register
- ex_memread_en / ex_memwrite_en / ex_regwrite_en  in  1 each  control
- ex_wb_sel  in  WB_SEL_W  writeback select
- ex_funct3  in  3  access size/sign (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU)
- flush  in  1  kill the MEM/WB update this cycle
- mem_stall  out  1  freeze upstream pipeline
- dmem_req  out  1  memory request valid
- dmem_we  out  1  write request
- dmem_be  out  DATA_W/8  byte enables
- dmem_addr  out  DATA_W  word-aligned address
- dmem_wdata  out  DATA_W  lane-shifted store data
- dmem_ready  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  DATA_W  read word
- wb_valid, wb_rd, wb_regwrite_en, wb_wb_sel, wb_alu_out, wb_load_data  out  MEM/WB register
- wb_misaligned  out  1  access fault flag for this WB entry

Function
REQ-004 The FSM SHALL have states IDLE, REQ (request held until dmem_ready), RESP (load waiting for dmem_rvalid).
REQ-005 In IDLE, an ex_valid access with memread or memwrite and aligned address SHALL assert dmem_req in the same cycle, with mem_stall=1 until completion.
REQ-006 A request accepted in the cycle it is issued (dmem_ready=1) SHALL complete a store that cycle; for a load the FSM SHALL go to RESP. If not accepted, the FSM SHALL go to REQ.
REQ-007 dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata SHALL stay stable from issue until dmem_ready.
REQ-008 A load SHALL complete on the dmem_rvalid cycle; dmem_rvalid in the acceptance cycle SHALL be honoured, giving a zero-wait load with no stall.
REQ-009 Non-memory instructions SHALL pass to MEM/WB in one cycle with no stall.
REQ-010 dmem_addr SHALL be ex_alu_out with bits[1:0] cleared.
REQ-011 Store byte enables SHALL be: SB 0001<<a[1:0]; SH 0011<<a[1:0]; SW 1111. Store data SHALL be replicated across lanes.
REQ-012 Load data SHALL be lane-selected by a[1:0], then sign-extended (LB/LH) or zero-extended (LBU/LHU).
REQ-013 Misalignment SHALL be defined as halfword with a[0]=1, or word with a[1:0]!=0. A misaligned access SHALL issue no dmem_req, no stall, and SHALL produce wb_misaligned=1 and wb_regwrite_en=0.
REQ-014 MEM/WB SHALL capture only on a completion cycle or a non-memory cycle. While stalled it SHALL load a bubble (wb_valid=0, wb_regwrite_en=0).
REQ-015 With flush=1, the MEM/WB update SHALL be a bubble. An outstanding transaction SHALL still finish, but its result SHALL be discarded.
REQ-016 ex_valid=0 SHALL produce a bubble and no request.

Reset
REQ-017 rst SHALL immediately force the FSM to IDLE, all wb_* outputs to 0, dmem_req=0 and mem_stall=0, including mid-transaction. A late dmem_rvalid after reset SHALL be ignored.

Structure
REQ-018 A shared package SHALL hold the funct3 size/sign constants, the FSM state encoding and the WB_SEL encodings.
REQ-019 Byte-enable generation, store lane shift and load extract/extend SHALL live in sub-module mem_align (combinational). The FSM and pipeline register SHALL live in mem_stage.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- SB at 0x1003, data 0x000000AB, ready=1 -> be=1000, wdata=0xABABABAB, no stall, wb_regwrite_en=0.
- LB at 0x1001, rdata 0x0000_80_00, zero-wait -> wb_load_data=0xFFFFFF80. LBU at the same address -> 0x00000080.
- LW at 0x2000, ready held 0 for 3 cycles, rvalid 2 cycles later -> mem_stall high for 5 cycles, address stable, one wb_valid pulse.
- LH at 0x3001 -> no dmem_req, wb_misaligned=1, wb_regwrite_en=0.
- flush during RESP -> the transaction finishes, wb_valid stays 0.
- rst asserted in REQ -> dmem_req=0 immediately, state IDLE, a later rvalid is ignored.
